fetch_stage: RTL and testbench

//   Instruction fetch stage. Holds the PC and issues one request at a time to

---
 rtl/fetch_stage.sv | 146 ++++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and
// hands each fetched word to decode with its PC and PC+4; execute may redirect.
module fetch_stage #(
  parameter int             W        = 32,
  parameter logic [W-1:0]   RESET_PC = {W{1'b0}}
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [W-1:0]  imem_addr,
  input  logic          imem_rsp_valid,
  input  logic [31:0]   imem_rsp_data,
  input  logic          redirect_valid,
  input  logic [W-1:0]  redirect_pc,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_instr,
  output logic [W-1:0]  id_pc,
  output logic [W-1:0]  id_pc_plus4
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [W-1:0] PC_STEP = {{(W-3){1'b0}}, 3'b100};
  localparam logic [31:0]  NOP     = 32'h0000_0013;

  state_t        state_r, state_s;
  logic [W-1:0]  pc_r, pc_s;
  logic [W-1:0]  req_pc_r, req_pc_s;
  logic          discard_r, discard_s;
  logic          id_valid_s;
  logic [31:0]   id_instr_s;
  logic [W-1:0]  id_pc_s, id_pc_plus4_s;
  logic [W-1:0]  redir_pc_s;

  assign redir_pc_s = {redirect_pc[W-1:2], 2'b00};

  // Request lines decode state and pc directly; held low while in reset.
  assign imem_req_valid = rst_n & (state_r == S_REQ);
  assign imem_addr      = pc_r;

  // Next-state and next-output logic; a redirect overrides everything else.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    req_pc_s      = req_pc_r;
    discard_s     = discard_r;
    id_valid_s    = id_valid;
    id_instr_s    = id_instr;
    id_pc_s       = id_pc;
    id_pc_plus4_s = id_pc_plus4;
    case (state_r)
      S_REQ: begin
        if (redirect_valid) begin
          pc_s       = redir_pc_s;
          id_valid_s = 1'b0;
          if (imem_req_ready) begin
            // imem already took the old address; its answer must be thrown away
            state_s   = S_WAIT;
            discard_s = 1'b1;
          end else begin
            state_s = S_REQ;
          end
        end else if (imem_req_ready) begin
          req_pc_s = pc_r;
          pc_s     = pc_r + PC_STEP;
          state_s  = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_s       = redir_pc_s;
          id_valid_s = 1'b0;
          if (imem_rsp_valid) begin
            discard_s = 1'b0;
            state_s   = S_REQ;
          end else begin
            discard_s = 1'b1;
            state_s   = S_WAIT;
          end
        end else if (imem_rsp_valid) begin
          if (discard_r) begin
            discard_s = 1'b0;
            state_s   = S_REQ;
          end else begin
            id_instr_s    = imem_rsp_data;
            id_pc_s       = req_pc_r;
            id_pc_plus4_s = req_pc_r + PC_STEP;
            id_valid_s    = 1'b1;
            state_s       = S_HOLD;
          end
        end else begin
          state_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_s       = redir_pc_s;
          id_valid_s = 1'b0;
          state_s    = S_REQ;
        end else if (id_ready) begin
          id_valid_s = 1'b0;
          state_s    = S_REQ;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: begin
        state_s    = S_REQ;
        discard_s  = 1'b0;
        id_valid_s = 1'b0;
      end
    endcase
  end

  // State, PC and decode-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_REQ;
      pc_r        <= RESET_PC;
      req_pc_r    <= RESET_PC;
      discard_r   <= 1'b0;
      id_valid    <= 1'b0;
      id_instr    <= NOP;
      id_pc       <= RESET_PC;
      id_pc_plus4 <= RESET_PC + PC_STEP;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      req_pc_r    <= req_pc_s;
      discard_r   <= discard_s;
      id_valid    <= id_valid_s;
      id_instr    <= id_instr_s;
      id_pc       <= id_pc_s;
      id_pc_plus4 <= id_pc_plus4_s;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: two instances (RESET_PC 0x100 and 0xFFFF_FFFC)
// share every input, so the second one exercises PC wrap under identical timing.
module tb_fetch_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc_a;
    logic [31:0] pc_b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_ready_s, imem_rsp_valid_s, redirect_valid_s, id_ready_s;
  logic [31:0] imem_rsp_data_s, redirect_pc_s;

  logic        req_valid_a_s, id_valid_a_s, req_valid_b_s, id_valid_b_s;
  logic [31:0] addr_a_s, instr_a_s, pc_a_s, pc4_a_s;
  logic [31:0] addr_b_s, instr_b_s, pc_b_s, pc4_b_s;

  exp_t        sb_q[$];
  logic [31:0] mpc_a, mpc_b;
  int          n_vec = 0;
  int          n_err = 0;

  fetch_stage #(.W(32), .RESET_PC(32'h0000_0100)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid_a_s), .imem_req_ready(imem_req_ready_s), .imem_addr(addr_a_s),
    .imem_rsp_valid(imem_rsp_valid_s), .imem_rsp_data(imem_rsp_data_s),
    .redirect_valid(redirect_valid_s), .redirect_pc(redirect_pc_s),
    .id_valid(id_valid_a_s), .id_ready(id_ready_s), .id_instr(instr_a_s),
    .id_pc(pc_a_s), .id_pc_plus4(pc4_a_s)
  );

  fetch_stage #(.W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid_b_s), .imem_req_ready(imem_req_ready_s), .imem_addr(addr_b_s),
    .imem_rsp_valid(imem_rsp_valid_s), .imem_rsp_data(imem_rsp_data_s),
    .redirect_valid(redirect_valid_s), .redirect_pc(redirect_pc_s),
    .id_valid(id_valid_b_s), .id_ready(id_ready_s), .id_instr(instr_b_s),
    .id_pc(pc_b_s), .id_pc_plus4(pc4_b_s)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_redirect_model(input logic [31:0] tgt);
    mpc_a = {tgt[31:2], 2'b00};
    mpc_b = {tgt[31:2], 2'b00};
  endtask

  // Wait for a request, check both addresses, accept it.
  task automatic handshake();
    int t = 0;
    while (!req_valid_a_s && t < 10) begin tick(); t++; end
    check_eq("req_valid", {31'd0, req_valid_a_s}, 32'd1);
    check_eq("addr_a", addr_a_s, mpc_a);
    check_eq("addr_b", addr_b_s, mpc_b);
    imem_req_ready_s = 1'b1;
    tick();
    imem_req_ready_s = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] data, input bit keep);
    handshake();
    if (keep) sb_q.push_back('{instr: data, pc_a: mpc_a, pc_b: mpc_b});
    mpc_a = mpc_a + 32'd4;
    mpc_b = mpc_b + 32'd4;
    imem_rsp_valid_s = 1'b1;
    imem_rsp_data_s  = data;
    tick();
    imem_rsp_valid_s = 1'b0;
  endtask

  task automatic consume(input int hold);
    int t = 0;
    exp_t e;
    while (!id_valid_a_s && t < 10) begin tick(); t++; end
    check_eq("id_valid", {31'd0, id_valid_a_s}, 32'd1);
    if (sb_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_empty: got an instruction 0x%08h expected none", instr_a_s);
    end else begin
      e = sb_q[0];
      for (int i = 0; i < hold; i++) begin
        check_eq("hold_valid", {31'd0, id_valid_a_s}, 32'd1);
        check_eq("hold_instr", instr_a_s, e.instr);
        check_eq("hold_pc", pc_a_s, e.pc_a);
        check_eq("hold_noreq", {31'd0, req_valid_a_s}, 32'd0);
        tick();
      end
      e = sb_q.pop_front();
      check_eq("instr_a", instr_a_s, e.instr);
      check_eq("pc_a", pc_a_s, e.pc_a);
      check_eq("pc4_a", pc4_a_s, e.pc_a + 32'd4);
      check_eq("instr_b", instr_b_s, e.instr);
      check_eq("pc_b", pc_b_s, e.pc_b);
      check_eq("pc4_b", pc4_b_s, e.pc_b + 32'd4);
      id_ready_s = 1'b1;
      tick();
      id_ready_s = 1'b0;
      check_eq("id_valid_drop", {31'd0, id_valid_a_s}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    imem_req_ready_s = 1'b0; imem_rsp_valid_s = 1'b0; imem_rsp_data_s = 32'd0;
    redirect_valid_s = 1'b0; redirect_pc_s = 32'd0; id_ready_s = 1'b0;
    mpc_a = 32'h0000_0100;
    mpc_b = 32'hFFFF_FFFC;
    repeat (3) @(negedge clk);
    check_eq("rst_id_valid", {31'd0, id_valid_a_s}, 32'd0);
    check_eq("rst_req_valid", {31'd0, req_valid_a_s}, 32'd0);
    check_eq("rst_instr", instr_a_s, 32'h0000_0013);
    check_eq("rst_pc", pc_a_s, 32'h0000_0100);
    check_eq("rst_pc_b", pc_b_s, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // straight line, then backpressure on the third instruction
    fetch(32'h0050_0093, 1'b1); consume(0);
    fetch(32'h00A0_0113, 1'b1); consume(0);
    fetch(32'h0030_0193, 1'b1); consume(5);

    // response arriving outside S_WAIT must be ignored
    imem_rsp_valid_s = 1'b1; imem_rsp_data_s = 32'hDEAD_0001;
    tick();
    imem_rsp_valid_s = 1'b0;
    check_eq("stray_rsp", {31'd0, id_valid_a_s}, 32'd0);

    // redirect while waiting, response follows and is dropped
    handshake();
    redirect_valid_s = 1'b1; redirect_pc_s = 32'h0000_0203;
    tick();
    redirect_valid_s = 1'b0;
    set_redirect_model(32'h0000_0203);
    imem_rsp_valid_s = 1'b1; imem_rsp_data_s = 32'hDEAD_0002;
    tick();
    imem_rsp_valid_s = 1'b0;
    check_eq("wait_redir_drop", {31'd0, id_valid_a_s}, 32'd0);
    fetch(32'h0040_0213, 1'b1); consume(0);

    // redirect in S_REQ without ready, then together with ready
    redirect_valid_s = 1'b1; redirect_pc_s = 32'h0000_02F0;
    tick();
    redirect_valid_s = 1'b0;
    set_redirect_model(32'h0000_02F0);
    check_eq("req_redir_addr", addr_a_s, 32'h0000_02F0);
    redirect_valid_s = 1'b1; redirect_pc_s = 32'h0000_0300;
    handshake();
    redirect_valid_s = 1'b0;
    set_redirect_model(32'h0000_0300);
    imem_rsp_valid_s = 1'b1; imem_rsp_data_s = 32'hDEAD_0003;
    tick();
    imem_rsp_valid_s = 1'b0;
    check_eq("stale_req_drop", {31'd0, id_valid_a_s}, 32'd0);
    fetch(32'h0060_0313, 1'b1); consume(0);

    // redirect in S_HOLD together with id_ready: held instruction is lost
    fetch(32'hDEAD_0004, 1'b0);
    check_eq("hold_before_redir", {31'd0, id_valid_a_s}, 32'd1);
    id_ready_s = 1'b1; redirect_valid_s = 1'b1; redirect_pc_s = 32'h0000_0400;
    tick();
    id_ready_s = 1'b0; redirect_valid_s = 1'b0;
    set_redirect_model(32'h0000_0400);
    check_eq("hold_redir_drop", {31'd0, id_valid_a_s}, 32'd0);
    fetch(32'h0070_0393, 1'b1); consume(0);

    // redirect in S_WAIT coinciding with the response
    handshake();
    imem_rsp_valid_s = 1'b1; imem_rsp_data_s = 32'hDEAD_0005;
    redirect_valid_s = 1'b1; redirect_pc_s = 32'h0000_0500;
    tick();
    imem_rsp_valid_s = 1'b0; redirect_valid_s = 1'b0;
    set_redirect_model(32'h0000_0500);
    check_eq("wait_rsp_redir", {31'd0, id_valid_a_s}, 32'd0);
    check_eq("wait_rsp_req", {31'd0, req_valid_a_s}, 32'd1);
    fetch(32'h0080_0413, 1'b1); consume(0);

    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
